instr_cache_tag_refill: RTL
===========================

# instr_cache_tag_refill

Write-side controller for the instruction-cache tag array. It accepts line-refill requests from the fetch miss path, chooses a victim way, and issues one tag write per refill. It also performs a full-array invalidate (flush) by walking every set. It drives the tag-array write port; the tag-array read port is owned by the fetch stage and is out of scope for this block.

## Interface
- `ASSOC`, default `ICACHE_ASSOC` (4): number of ways; must be a power of 2, at least 2.
- `SETS`, default 64: number of sets; must be a power of 2.
- `LINE_BYTES`, default 64: line size; offset width OFS = log2(LINE_BYTES).
- `VADDR_W`, default `VADDR_WIDTH` (32): IDX = log2(SETS); TAG_W = VADDR_W − IDX − OFS.
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_refill_valid` in 1: refill request.
- `i_refill_vaddr` in VADDR_W: miss address.
- `o_refill_ready` out 1: refill accepted when valid and ready are both high.
- `o_refill_done` out 1: one-cycle pulse, coincident with the refill tag write.
- `o_refill_way` out log2(ASSOC): chosen way; valid while done is high.
- `i_flush_valid` in 1: flush request; held high until accepted.
- `o_flush_ready` out 1: flush accepted when valid and ready are both high.
- `o_flush_done` out 1: one-cycle pulse on the last flush write.
- `o_tag_we` out ASSOC: per-way write enable to the tag array.
- `o_tag_set` out IDX: set index being written.
- `o_tag_valid` out 1: valid bit to write.
- `o_tag_tag` out TAG_W: tag to write.

## Operation
- States: IDLE, WRITE, FLUSH.
- IDLE:
  - `o_flush_ready` = 1.
  - `o_refill_ready` = !i_flush_valid. Flush has priority when both requests are present.
  - On flush accept: go to FLUSH and clear the set counter to 0.
  - On refill accept:
    - Register set = vaddr[OFS+IDX−1:OFS] and tag = vaddr[VADDR_W−1:OFS+IDX].
    - Latch the victim way.
    - Go to WRITE.
- WRITE (1 cycle):
  - `o_tag_we` is one-hot at the victim way; `o_tag_valid` = 1; set and tag come from the registers.
  - `o_refill_done` = 1 and `o_refill_way` = victim.
  - Next state is IDLE.
- FLUSH:
  - Each cycle: `o_tag_we` = all ones, `o_tag_set` = counter, `o_tag_valid` = 0, `o_tag_tag` = 0.
  - The counter increments each cycle.
  - When counter = SETS−1: pulse `o_flush_done`, go to IDLE, reset the counter to 0.
- Both ready outputs are 0 in WRITE and FLUSH.
- Victim selection (default, round-robin):
  - One global counter of width log2(ASSOC); reset value 0.
  - Victim = counter value at refill acceptance; the counter then increments and wraps modulo ASSOC.
  - Flush does not change the counter.
- Reset:
  - State goes to IDLE; set counter and victim counter go to 0.
  - All write/done outputs are 0: `o_tag_we` = 0, `o_tag_set` = 0, `o_tag_valid` = 0, `o_tag_tag` = 0, `o_refill_done` = 0, `o_refill_way` = 0, `o_flush_done` = 0.
  - Ready outputs are 0 while i_rst_n = 0. Both are 1 in the first cycle after release, unless i_flush_valid is high, which blocks `o_refill_ready`.
- Reset mid-flush or mid-WRITE aborts the operation. No done pulse is issued. Partial invalidation is acceptable.

## Timing
- All outputs except the two ready signals are registered-state decodes; ready signals are combinational from state and i_flush_valid.
- Refill:
  - Accepted at edge N; tag write and `o_refill_done` in cycle N+1; ready again in cycle N+2.
  - Maximum throughput is 1 refill per 2 cycles.
- Flush:
  - Accepted at edge N; writes to sets 0..SETS−1 occur in cycles N+1..N+SETS.
  - `o_flush_done` in cycle N+SETS; IDLE in cycle N+SETS+1.
- Requests arriving in WRITE or FLUSH wait. Inputs are not sampled until IDLE.
- `o_tag_we` is never nonzero in IDLE.

## Configuration
- `ICACHE_VICTIM_LFSR_EN` defined:
  - Victim = lfsr[log2(ASSOC)−1:0] at acceptance.
  - lfsr is 8 bits, polynomial x^8+x^6+x^5+x^4+1 (Fibonacci form, shift left, feedback into bit 0).
  - Reset value 8'h01; advances every cycle, including in FLUSH.
  - The round-robin counter is not built.
- `ICACHE_VICTIM_LFSR_EN` undefined: round-robin victim as described in Operation.

## Test plan
(Defaults: ASSOC=4, SETS=64, LINE_BYTES=64, VADDR_W=32.)
- Reset, then refill with vaddr 0x1234_5678 -> next cycle `o_tag_we`=4'b0001, set=0x19, tag=0x12345, `o_tag_valid`=1, done=1, way=0.
- Four back-to-back refills (round-robin) -> ways 0,1,2,3; a fifth refill -> way 0; `o_refill_ready` low every other cycle.
- Flush accepted -> 64 consecutive cycles with `o_tag_we`=4'b1111, `o_tag_set` 0..63, `o_tag_valid`=0; `o_flush_done` only with set 63; ready in the following cycle.
- i_flush_valid and i_refill_valid both high in IDLE -> flush accepted, refill ready=0; the refill is accepted on the first IDLE cycle after flush done.
- Reset asserted at flush set 20 -> the next cycle shows `o_tag_we`=0 and no `o_flush_done`; a new flush restarts at set 0.
- With `ICACHE_VICTIM_LFSR_EN`: refill accepted in the first cycle after reset -> way = 8'h01[1:0] = 1; victims follow the LFSR sequence.

Source files
------------

// File: rtl/instr_cache_tag_refill.sv
// Instruction-cache tag-array write controller.
// Accepts line-refill requests, picks a victim way and issues one tag write
// per refill; also invalidates the whole array (flush) by walking every set.
// Optional feature macro: ICACHE_VICTIM_LFSR_EN selects an 8-bit LFSR victim
// picker instead of the default round-robin counter.
// Handshake rule for both request channels: a request transfers on a rising
// edge where valid and ready are both high; ready depends only on state, reset
// and i_flush_valid, never on the request's own valid.

`ifndef ICACHE_ASSOC
`define ICACHE_ASSOC 4
`endif

`ifndef VADDR_WIDTH
`define VADDR_WIDTH 32
`endif

module instr_cache_tag_refill #(
    parameter int ASSOC      = `ICACHE_ASSOC,
    parameter int SETS       = 64,
    parameter int LINE_BYTES = 64,
    parameter int VADDR_W    = `VADDR_WIDTH,
    localparam int WAY_W     = $clog2(ASSOC),
    localparam int IDX       = $clog2(SETS),
    localparam int OFS       = $clog2(LINE_BYTES),
    localparam int TAG_W     = VADDR_W - IDX - OFS
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_refill_valid,
    input  logic [VADDR_W-1:0] i_refill_vaddr,
    output logic               o_refill_ready,
    output logic               o_refill_done,
    output logic [WAY_W-1:0]   o_refill_way,
    input  logic               i_flush_valid,
    output logic               o_flush_ready,
    output logic               o_flush_done,
    output logic [ASSOC-1:0]   o_tag_we,
    output logic [IDX-1:0]     o_tag_set,
    output logic               o_tag_valid,
    output logic [TAG_W-1:0]   o_tag_tag,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [IDX-1:0] LAST_SET = IDX'(SETS - 1);

    state_e             state_q, state_d;
    logic [IDX-1:0]     set_cnt_q, set_cnt_d;
    logic [IDX-1:0]     ref_set_q, ref_set_d;
    logic [TAG_W-1:0]   ref_tag_q, ref_tag_d;
    logic [WAY_W-1:0]   way_q, way_d;
    logic [WAY_W-1:0]   victim;
    logic               refill_acc;
    logic               flush_acc;

    // Line-offset bits of the miss address do not matter for a tag write.
    logic unused_vaddr_ofs;
    assign unused_vaddr_ofs = ^i_refill_vaddr[OFS-1:0];

`ifdef ICACHE_VICTIM_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Free-running LFSR, x^8+x^6+x^5+x^4+1, shifts every cycle in every state.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        victim = lfsr_q[WAY_W-1:0];
    end
`else
    logic [WAY_W-1:0] rr_q, rr_d;

    // Round-robin victim: advances only when a refill is accepted.
    always_comb begin
        victim = rr_q;
        rr_d   = rr_q;
        if (refill_acc) begin
            rr_d = rr_q + 1'b1;
        end
    end
`endif

    // Request acceptance; flush wins over a simultaneous refill.
    always_comb begin
        flush_acc  = (state_q == ST_IDLE) && i_flush_valid;
        refill_acc = (state_q == ST_IDLE) && i_refill_valid && !i_flush_valid;
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        set_cnt_d = set_cnt_q;
        ref_set_d = ref_set_q;
        ref_tag_d = ref_tag_q;
        way_d     = way_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_acc) begin
                    state_d   = ST_FLUSH;
                    set_cnt_d = '0;
                end else if (refill_acc) begin
                    state_d   = ST_WRITE;
                    ref_set_d = i_refill_vaddr[OFS+IDX-1:OFS];
                    ref_tag_d = i_refill_vaddr[VADDR_W-1:OFS+IDX];
                    way_d     = victim;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                if (set_cnt_q == LAST_SET) begin
                    state_d   = ST_IDLE;
                    set_cnt_d = '0;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                set_cnt_d = '0;
            end
        endcase
    end

    // Single state register block with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            set_cnt_q <= '0;
            ref_set_q <= '0;
            ref_tag_q <= '0;
            way_q     <= '0;
`ifdef ICACHE_VICTIM_LFSR_EN
            lfsr_q    <= 8'h01;
`else
            rr_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            set_cnt_q <= set_cnt_d;
            ref_set_q <= ref_set_d;
            ref_tag_q <= ref_tag_d;
            way_q     <= way_d;
`ifdef ICACHE_VICTIM_LFSR_EN
            lfsr_q    <= lfsr_d;
`else
            rr_q      <= rr_d;
`endif
        end
    end

    // Ready signals: combinational, forced low while reset is held.
    always_comb begin
        o_flush_ready  = i_rst_n && (state_q == ST_IDLE);
        o_refill_ready = i_rst_n && (state_q == ST_IDLE) && !i_flush_valid;
    end

    // Tag-port and done outputs decoded from registered state only.
    always_comb begin
        o_tag_we      = '0;
        o_tag_set     = '0;
        o_tag_valid   = 1'b0;
        o_tag_tag     = '0;
        o_refill_done = 1'b0;
        o_refill_way  = '0;
        o_flush_done  = 1'b0;
        case (state_q)
            ST_WRITE: begin
                o_tag_we      = {{(ASSOC-1){1'b0}}, 1'b1} << way_q;
                o_tag_set     = ref_set_q;
                o_tag_valid   = 1'b1;
                o_tag_tag     = ref_tag_q;
                o_refill_done = 1'b1;
                o_refill_way  = way_q;
            end
            ST_FLUSH: begin
                o_tag_we     = '1;
                o_tag_set    = set_cnt_q;
                o_flush_done = (set_cnt_q == LAST_SET);
            end
            default: begin
            end
        endcase
    end

    assign o_dbg_state = state_q;

endmodule
